instruction_fetch: RTL and testbench

- Fetch stage directly upstream of the control signal generator.
- Owns the PC and runs a req/ack handshake with instruction memory, one request outstanding at a time.
- Registers each fetched word and presents it with a valid/ready handshake to decode.
- Decode receives the word split into `type` (3b) and `op` (5b), which drive the control signal generator.
- Accepts single-cycle PC redirects for branches and jumps (`jal`/`jr`).

---
 rtl/instruction_fetch_pkg.sv | 39 +++
 rtl/pc_register.sv | 32 +++
 rtl/instruction_fetch.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared field positions, type encodings and fetch state enum for the fetch stage.
// Defining FETCH_HALT_EN adds the S_HALT state.
package instruction_fetch_pkg;

  localparam int TYPE_W = 3;
  localparam int OP_W   = 5;

  localparam logic [2:0] TYPE_BRANCH = 3'b000;
  localparam logic [2:0] TYPE_ALU    = 3'b001;
  localparam logic [2:0] TYPE_CONST  = 3'b010;
  localparam logic [2:0] TYPE_MEM    = 3'b100;
  localparam logic [2:0] TYPE_JUMP   = 3'b110;
  localparam logic [2:0] TYPE_HALT   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_OUT  = 3'd2,
    S_DROP = 3'd3
`ifdef FETCH_HALT_EN
    , S_HALT = 3'd4
`endif
  } fetch_state_e;

  // Bit position of the type field MSB (top of the word).
  function automatic int type_msb(input int instr_w);
    return instr_w - 1;
  endfunction

  // Bit position of the op field MSB (directly below the type field).
  function automatic int op_msb(input int instr_w);
    return instr_w - 1 - TYPE_W;
  endfunction

  function automatic logic is_halt(input logic [2:0] instr_type);
    return instr_type == TYPE_HALT;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter for the fetch stage: synchronous reset, redirect load and
// wrapping increment, with load taking priority over increment.
module pc_register #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_r;

  // PC update; the increment wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= load_pc;
    end else if (inc) begin
      pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, runs a single-outstanding req/ack to instruction
// memory and hands registered words to decode. FETCH_HALT_EN enables HALT.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [2:0]         if_type,
  output logic [4:0]         if_op,
  output logic               halted
);

  localparam int TYPE_MSB = type_msb(INSTR_W);
  localparam int OP_MSB   = op_msb(INSTR_W);

  fetch_state_e       state_r, state_s;
  logic [ADDR_W-1:0]  pc_s;
  logic [ADDR_W-1:0]  drop_addr_r;
  logic               pc_load_s;
  logic               capture_s;
  logic               imem_req_r;
  logic               if_valid_r;
  logic [INSTR_W-1:0] if_instr_r;
  logic [ADDR_W-1:0]  if_pc_r;
`ifdef FETCH_HALT_EN
  logic               halt_pend_r;
  logic               halted_r;
`endif

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load_s),
    .load_pc (redirect_pc),
    .inc     (capture_s),
    .pc      (pc_s)
  );

  // Next-state logic; a redirect always wins over ack and the decode handshake.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    pc_load_s = redirect_valid;
    case (state_r)
      S_IDLE: state_s = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          // Without an ack the old address must finish on the bus first.
          if (imem_ack) state_s = S_REQ;
          else          state_s = S_DROP;
        end else if (imem_ack) begin
          state_s   = S_OUT;
          capture_s = 1'b1;
        end else begin
          state_s = S_REQ;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          state_s = S_REQ;
        end else if (if_ready) begin
`ifdef FETCH_HALT_EN
          if (halt_pend_r) state_s = S_HALT;
          else             state_s = S_REQ;
`else
          state_s = S_REQ;
`endif
        end else begin
          state_s = S_OUT;
        end
      end
      S_DROP: begin
        if (imem_ack) state_s = S_REQ;
        else          state_s = S_DROP;
      end
`ifdef FETCH_HALT_EN
      S_HALT: begin
        state_s   = S_HALT;
        pc_load_s = 1'b0;
      end
`endif
      default: state_s = S_IDLE;
    endcase
  end

  // State, handshake flags and captured instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      imem_req_r  <= 1'b0;
      if_valid_r  <= 1'b0;
      if_instr_r  <= {INSTR_W{1'b0}};
      if_pc_r     <= {ADDR_W{1'b0}};
      drop_addr_r <= {ADDR_W{1'b0}};
`ifdef FETCH_HALT_EN
      halt_pend_r <= 1'b0;
      halted_r    <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      imem_req_r <= (state_s == S_REQ) || (state_s == S_DROP);
      if_valid_r <= (state_s == S_OUT);
      if (capture_s) begin
        if_instr_r <= imem_rdata;
        if_pc_r    <= pc_s;
`ifdef FETCH_HALT_EN
        halt_pend_r <= is_halt(imem_rdata[TYPE_MSB -: TYPE_W]);
`endif
      end
      if ((state_r == S_REQ) && (state_s == S_DROP)) begin
        drop_addr_r <= pc_s;
      end
`ifdef FETCH_HALT_EN
      halted_r <= (state_s == S_HALT);
`endif
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = (state_r == S_DROP) ? drop_addr_r : pc_s;
  assign if_valid  = if_valid_r;
  assign if_instr  = if_instr_r;
  assign if_pc     = if_pc_r;
  assign if_type   = if_instr_r[TYPE_MSB -: TYPE_W];
  assign if_op     = if_instr_r[OP_MSB -: OP_W];
`ifdef FETCH_HALT_EN
  assign halted    = halted_r;
`else
  assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: memory model plus scoreboard of
// expected request addresses and delivered PCs.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr;
  logic [15:0] if_pc;
  logic [2:0]  if_type;
  logic [4:0]  if_op;
  logic        halted;

  logic        w_imem_req, w_if_valid, w_halted;
  logic [15:0] w_imem_addr, w_if_pc;
  logic [31:0] w_if_instr;
  logic [2:0]  w_if_type;
  logic [4:0]  w_if_op;

  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          wait_cnt = 0;
  bit          rdy_en = 1'b0;
  logic [15:0] addr_q[$];
  logic [15:0] out_q[$];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_type(if_type), .if_op(if_op), .halted(halted)
  );

  instruction_fetch #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(w_if_valid), .if_ready(if_ready), .if_instr(w_if_instr),
    .if_pc(w_if_pc), .if_type(w_if_type), .if_op(w_if_op), .halted(w_halted)
  );

  // Memory contents: type = 3*addr, op = addr+7, then a marker byte and the address.
  function automatic logic [31:0] word(input logic [15:0] a);
    logic [2:0] t;
    logic [4:0] o;
    t = 3'(a * 3);
    o = 5'(a + 16'd7);
    return {t, o, 8'hA5, a};
  endfunction

  // One clock: scoreboard at negedge, then drive memory/ready 2ns after posedge.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    if (!rst) begin
      if (imem_req && imem_ack && addr_q.size() > 0) begin
        e = addr_q.pop_front();
        checks++;
        if (imem_addr !== e) begin
          failures++;
          $display("FAIL imem_addr: got %h expected %h", imem_addr, e);
        end
      end
      if (if_valid && if_ready && !redirect_valid) begin
        if (out_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_delivery: got if_pc %h expected nothing", if_pc);
        end else begin
          e = out_q.pop_front();
          checks++;
          if (if_pc !== e) begin
            failures++; $display("FAIL if_pc: got %h expected %h", if_pc, e);
          end
          checks++;
          if (if_instr !== word(e)) begin
            failures++; $display("FAIL if_instr: got %h expected %h", if_instr, word(e));
          end
          checks++;
          if (if_type !== 3'(e * 3)) begin
            failures++; $display("FAIL if_type: got %b expected %b", if_type, 3'(e * 3));
          end
          checks++;
          if (if_op !== 5'(e + 16'd7)) begin
            failures++; $display("FAIL if_op: got %h expected %h", if_op, 5'(e + 16'd7));
          end
        end
      end
    end
    @(posedge clk);
    #2;
    if (!rst && imem_req) begin
      if (wait_cnt >= lat) begin
        imem_ack = 1'b1; imem_rdata = word(imem_addr); wait_cnt = 0;
      end else begin
        imem_ack = 1'b0; wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0; wait_cnt = 0;
    end
    if_ready = rdy_en;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy_en = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    addr_q.delete(); out_q.delete();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (out_q.size() != 0 && n < budget) begin tick(); n++; end
    checks++;
    if (out_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", out_q.size());
    end
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !if_valid; i++) tick();
    checks++;
    if (if_valid !== 1'b1) begin
      failures++; $display("FAIL wait_valid: got %b expected 1", if_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    redirect_valid = 1'b1; redirect_pc = 16'h1234; if_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks += 5;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
    if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h expected 0", if_instr); end
    if (if_pc !== 16'h0) begin failures++; $display("FAIL rst_pc: got %h expected 0", if_pc); end
    if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted: got %b expected 0", halted); end
    rst = 1'b0; redirect_valid = 1'b0;
    @(posedge clk);
    #2;
    checks += 4;
    if (if_instr !== 32'h0) begin failures++; $display("FAIL idle_ack_ignored: got %h expected 0", if_instr); end
    if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req: got %b expected 1", imem_req); end
    if (imem_addr !== 16'h0000) begin failures++; $display("FAIL first_addr: got %h expected 0000", imem_addr); end
    if (w_imem_addr !== 16'hFFFF) begin failures++; $display("FAIL w_first_addr: got %h expected ffff", w_imem_addr); end
    imem_ack = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset(); lat = 1; rdy_en = 1'b1;
    for (int i = 0; i < 3; i++) begin addr_q.push_back(16'(i)); out_q.push_back(16'(i)); end
    run_until_empty(60);
    checks++;
    if (addr_q.size() != 0) begin failures++; $display("FAIL seq_addrs: got %0d unseen expected 0", addr_q.size()); end
  endtask

  task automatic test_stall();
    do_reset(); lat = 0; rdy_en = 1'b0;
    addr_q.push_back(16'h0000);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 4;
      if (if_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b expected 1", if_valid); end
      if (if_instr !== word(16'h0000)) begin failures++; $display("FAIL stall_instr: got %h expected %h", if_instr, word(16'h0000)); end
      if (if_pc !== 16'h0000) begin failures++; $display("FAIL stall_pc: got %h expected 0000", if_pc); end
      if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req: got %b expected 0", imem_req); end
    end
    addr_q.push_back(16'h0001);
    out_q.push_back(16'h0000); out_q.push_back(16'h0001);
    rdy_en = 1'b1;
    run_until_empty(40);
  endtask

  task automatic test_redirect_req();
    do_reset(); lat = 4; rdy_en = 1'b1;
    addr_q.push_back(16'h0000); addr_q.push_back(16'h0040);
    out_q.push_back(16'h0040); out_q.push_back(16'h0041);
    for (int i = 0; i < 10 && !imem_req; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick();
    checks += 2;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL drop_req: got %b expected 1", imem_req); end
    if (imem_addr !== 16'h0000) begin failures++; $display("FAIL drop_addr: got %h expected 0000", imem_addr); end
    run_until_empty(80);
  endtask

  task automatic test_redirect_ack();
    do_reset(); lat = 1; rdy_en = 1'b1;
    addr_q.push_back(16'h0000); addr_q.push_back(16'h0080);
    out_q.push_back(16'h0080); out_q.push_back(16'h0081);
    for (int i = 0; i < 10 && !(imem_req && imem_ack); i++) tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0080;
    tick();
    checks += 3;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL ack_redir_valid: got %b expected 0", if_valid); end
    if (if_instr !== 32'h0) begin failures++; $display("FAIL ack_redir_instr: got %h expected 0", if_instr); end
    if (imem_addr !== 16'h0080) begin failures++; $display("FAIL ack_redir_addr: got %h expected 0080", imem_addr); end
    run_until_empty(40);
  endtask

  task automatic test_redirect_out();
    do_reset(); lat = 0; rdy_en = 1'b0;
    addr_q.push_back(16'h0000);
    wait_valid(20);
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0123;
    tick();
    checks++;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL out_redir_valid: got %b expected 0", if_valid); end
    addr_q.push_back(16'h0123);
    out_q.push_back(16'h0123); out_q.push_back(16'h0124);
    rdy_en = 1'b1;
    run_until_empty(40);
  endtask

  task automatic test_reset_pc_wrap();
    logic [15:0] wexp [2];
    int idx = 0;
    wexp[0] = 16'hFFFF; wexp[1] = 16'h0000;
    do_reset(); lat = 1; rdy_en = 1'b1;
    out_q.push_back(16'h0000); out_q.push_back(16'h0001);
    for (int i = 0; i < 40 && idx < 2; i++) begin
      tick();
      if (w_if_valid && if_ready && !redirect_valid) begin
        checks++;
        if (w_if_pc !== wexp[idx]) begin
          failures++; $display("FAIL wrap_pc: got %h expected %h", w_if_pc, wexp[idx]);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 2) begin failures++; $display("FAIL wrap_timeout: got %0d deliveries expected 2", idx); end
    run_until_empty(20);
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    do_reset(); lat = 0; rdy_en = 1'b1;
    for (int i = 0; i < 6; i++) out_q.push_back(16'(i));
    run_until_empty(60);
    checks++;
    if (halted !== 1'b1) begin failures++; $display("FAIL halt_set: got %b expected 1", halted); end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin redirect_valid = 1'b1; redirect_pc = 16'h0010; end
      tick();
      checks += 3;
      if (imem_req !== 1'b0) begin failures++; $display("FAIL halt_req: got %b expected 0", imem_req); end
      if (halted !== 1'b1) begin failures++; $display("FAIL halt_hold: got %b expected 1", halted); end
      if (if_valid !== 1'b0) begin failures++; $display("FAIL halt_valid: got %b expected 0", if_valid); end
    end
    do_reset();
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL halt_clear: got %b expected 0", halted); end
    addr_q.push_back(16'h0000); out_q.push_back(16'h0000);
    rdy_en = 1'b1;
    run_until_empty(20);
  endtask
`else
  task automatic test_type7_passthrough();
    do_reset(); lat = 0; rdy_en = 1'b1;
    for (int i = 0; i < 7; i++) out_q.push_back(16'(i));
    run_until_empty(80);
    checks += 2;
    if (halted !== 1'b0) begin failures++; $display("FAIL no_halt: got %b expected 0", halted); end
    if (imem_req !== 1'b1) begin failures++; $display("FAIL keeps_fetching: got %b expected 1", imem_req); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_req();
    test_redirect_ack();
    test_redirect_out();
    test_reset_pc_wrap();
`ifdef FETCH_HALT_EN
    test_halt();
`else
    test_type7_passthrough();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
